// File: rtl/wb_line_responder_if.sv
// Wishbone line-request bus between a CPU port (master) and wb_line_responder (slave).
interface wb_line_responder_if #(
  parameter int ADR_W = 12
);
  logic             CYC;
  logic             STB;
  logic             WE;
  logic [ADR_W-1:0] ADR;
  logic [127:0]     DAT_M;
  logic [15:0]      SEL;
  logic [127:0]     DAT_S;
  logic             ACK;
  logic             ERR;

  modport master (
    output CYC, STB, WE, ADR, DAT_M, SEL,
    input  DAT_S, ACK, ERR
  );

  modport slave (
    input  CYC, STB, WE, ADR, DAT_M, SEL,
    output DAT_S, ACK, ERR
  );
endinterface

// File: rtl/wb_line_responder.sv
// Wishbone slave answering 128-bit line requests from an internal line array after LATENCY wait
// cycles. Define WB_RESP_RANGE_ERR_EN to complete out-of-range requests with ERR instead of ACK.
module wb_line_responder #(
  parameter int DEPTH   = 256,
  parameter int LATENCY = 3,
  parameter int ADR_W   = 12
) (
  input  logic               clk,
  input  logic               rst,
  wb_line_responder_if.slave bus
);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
  localparam int LOAD  = (LATENCY > 0) ? LATENCY - 1 : 0;
  localparam logic [IDX_W:0] LIMIT = (IDX_W + 1)'(DEPTH);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] WAIT = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [IDX_W-1:0] idx_q;
  logic             we_q;
  logic [127:0]     dat_q;
  logic [15:0]      sel_q;
  logic             ack;
  logic             err;
  logic [127:0]     dat_s;

  logic [127:0] mem [DEPTH] = '{default: '0};

  logic [ADR_W-1:0] adr_in;
  logic             req;
  logic             go_resp;
  logic             c_we;
  logic             c_in_range;
  logic [IDX_W-1:0] c_idx;
  logic [IDX_W-1:0] c_safe;
  logic [127:0]     c_dat;
  logic [15:0]      c_sel;
  logic             unused_adr;

  assign adr_in     = bus.ADR;
  assign req        = bus.CYC & bus.STB;
  assign unused_adr = ^adr_in;

  // With LATENCY = 0 the RESP-entry edge is the acceptance edge, so the live bus is committed.
  always_comb begin
    c_idx = idx_q;
    c_we  = we_q;
    c_dat = dat_q;
    c_sel = sel_q;
    if (state == IDLE) begin
      c_idx = adr_in[IDX_W-1:0];
      c_we  = bus.WE;
      c_dat = bus.DAT_M;
      c_sel = bus.SEL;
    end
    c_in_range = ({1'b0, c_idx} < LIMIT);
    c_safe     = c_in_range ? c_idx : '0;
    go_resp    = ~rst & req &
                 (((state == IDLE) && (LATENCY == 0)) || ((state == WAIT) && (cnt == '0)));
  end

  always_ff @(posedge clk) begin
    if (go_resp && c_we && c_in_range) begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (c_sel[i]) mem[c_safe][8*i +: 8] <= c_dat[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      ack   <= 1'b0;
      err   <= 1'b0;
      dat_s <= '0;
    end else begin
      ack <= 1'b0;
      err <= 1'b0;
      case (state)
        IDLE: begin
          if (req) begin
            idx_q <= adr_in[IDX_W-1:0];
            we_q  <= bus.WE;
            dat_q <= bus.DAT_M;
            sel_q <= bus.SEL;
            if (LATENCY == 0) begin
              state <= RESP;
            end else begin
              cnt   <= CNT_W'(LOAD);
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!req)           state <= IDLE;
          else if (cnt == '0) state <= RESP;
          else                cnt   <= cnt - 1'b1;
        end
        default: state <= IDLE;
      endcase

      if (go_resp) begin
`ifdef WB_RESP_RANGE_ERR_EN
        ack <= c_in_range;
        err <= ~c_in_range;
        if (!c_we && c_in_range) dat_s <= mem[c_safe];
`else
        ack <= 1'b1;
        if (!c_we) dat_s <= c_in_range ? mem[c_safe] : '0;
`endif
      end
    end
  end

  assign bus.ACK   = ack;
  assign bus.ERR   = err;
  assign bus.DAT_S = dat_s;
endmodule

// File: tb/tb_wb_line_responder.sv
// Bench for wb_line_responder: one instance with DEPTH=200/LATENCY=3, one with DEPTH=256/LATENCY=0.
module tb_wb_line_responder;
  typedef struct {
    bit           which;
    bit           we;
    logic [11:0]  adr;
    logic [127:0] dat;
    logic [15:0]  sel;
    bit           exp_err;
    logic [127:0] exp_dat;
  } vec_t;

  typedef struct {
    bit           err;
    logic [127:0] dat;
  } exp_t;

`ifdef WB_RESP_RANGE_ERR_EN
  localparam bit RE = 1'b1;
`else
  localparam bit RE = 1'b0;
`endif

  localparam logic [127:0] D1   = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] PW   = 128'hAAAAAAAAAAAAAAAAAAAAAAAAAAAABEEF;
  localparam logic [127:0] D1P  = 128'h0123456789ABCDEF0123456789ABBEEF;
  localparam logic [127:0] ONES = '1;
  localparam logic [127:0] LA   = {8{16'h1111}};
  localparam logic [127:0] LB   = {8{16'h2222}};
  localparam logic [127:0] LC   = {4{32'hC0DEC0DE}};
  localparam logic [127:0] LP   = {4{32'h5A5A0F0F}};
  localparam logic [127:0] LQ   = {4{32'hDEADBEEF}};

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[$];
  exp_t sb[$];

  always #5 clk = ~clk;

  wb_line_responder_if #(.ADR_W(12)) bus3 ();
  wb_line_responder_if #(.ADR_W(12)) bus0 ();

  wb_line_responder #(.DEPTH(200), .LATENCY(3), .ADR_W(12)) u_dut3 (
    .clk(clk), .rst(rst), .bus(bus3.slave)
  );
  wb_line_responder #(.DEPTH(256), .LATENCY(0), .ADR_W(12)) u_dut0 (
    .clk(clk), .rst(rst), .bus(bus0.slave)
  );

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input bit which, input bit on, input bit we, input logic [11:0] adr,
                       input logic [127:0] dat, input logic [15:0] sel);
    if (which) begin
      bus0.CYC = on; bus0.STB = on; bus0.WE = we; bus0.ADR = adr; bus0.DAT_M = dat; bus0.SEL = sel;
    end else begin
      bus3.CYC = on; bus3.STB = on; bus3.WE = we; bus3.ADR = adr; bus3.DAT_M = dat; bus3.SEL = sel;
    end
  endtask

  task automatic sample(input bit which, output logic ack, output logic err, output logic [127:0] ds);
    if (which) begin
      ack = bus0.ACK; err = bus0.ERR; ds = bus0.DAT_S;
    end else begin
      ack = bus3.ACK; err = bus3.ERR; ds = bus3.DAT_S;
    end
  endtask

  // One request held until completion; checks latency, completion kind, DAT_S and pulse width.
  task automatic txn(input bit which, input bit we, input logic [11:0] adr, input logic [127:0] dat,
                     input logic [15:0] sel, input bit exp_err, input logic [127:0] exp_dat);
    int           lat;
    int           cyc;
    bit           got;
    logic         ack;
    logic         err;
    logic [127:0] ds;
    exp_t         e;
    lat = which ? 0 : 3;
    @(negedge clk);
    drive(which, 1'b1, we, adr, dat, sel);
    sb.push_back('{exp_err, exp_dat});
    cyc = 0;
    got = 1'b0;
    while (!got && cyc < 20) begin
      @(negedge clk);
      sample(which, ack, err, ds);
      if (ack || err) got = 1'b1;
      else cyc++;
    end
    drive(which, 1'b0, 1'b0, 12'h000, '0, '0);
    e = sb.pop_front();
    if (!got) begin
      chk("completion_timeout", 128'(got), 128'd1);
    end else begin
      chk("latency", 128'(cyc), 128'(lat));
      chk("ack", 128'(ack), 128'(!e.err));
      chk("err", 128'(err), 128'(e.err));
      chk("dat_s", ds, e.dat);
      @(negedge clk);
      sample(which, ack, err, ds);
      chk("pulse_end", 128'(ack | err), 128'd0);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic         ack;
    logic         err;
    logic [127:0] ds;
    logic [127:0] b2b_dat [7];
    bit           b2b_ack [7];

    drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0);
    drive(1'b1, 1'b0, 1'b0, 12'h000, '0, '0);

    vecs.push_back('{0, 1, 12'h010, D1,   16'hFFFF, 0,  128'd0});
    vecs.push_back('{0, 0, 12'h010, '0,   16'h0000, 0,  D1});
    vecs.push_back('{0, 1, 12'h010, PW,   16'h0003, 0,  D1});
    vecs.push_back('{0, 0, 12'h010, '0,   16'hFFFF, 0,  D1P});
    vecs.push_back('{0, 0, 12'h0C8, '0,   16'hFFFF, RE, RE ? D1P : 128'd0});
    vecs.push_back('{0, 0, 12'h110, '0,   16'h0000, 0,  D1P});
    vecs.push_back('{0, 1, 12'h011, ONES, 16'h0000, 0,  D1P});
    vecs.push_back('{0, 0, 12'h011, '0,   16'h0000, 0,  128'd0});
    vecs.push_back('{0, 1, 12'h0C9, ONES, 16'hFFFF, RE, 128'd0});
    vecs.push_back('{0, 0, 12'h0C9, '0,   16'h0000, RE, 128'd0});
    vecs.push_back('{1, 1, 12'h001, LA,   16'hFFFF, 0,  128'd0});
    vecs.push_back('{1, 1, 12'h002, LB,   16'hFFFF, 0,  128'd0});
    vecs.push_back('{1, 0, 12'h001, '0,   16'h0000, 0,  LA});
    vecs.push_back('{1, 0, 12'h002, '0,   16'h0000, 0,  LB});

    repeat (3) @(negedge clk);
    sample(1'b0, ack, err, ds);
    chk("rst_ack3", 128'(ack), 128'd0);
    chk("rst_err3", 128'(err), 128'd0);
    chk("rst_dat3", ds, 128'd0);
    sample(1'b1, ack, err, ds);
    chk("rst_ack0", 128'(ack), 128'd0);
    chk("rst_dat0", ds, 128'd0);
    rst = 1'b0;

    foreach (vecs[i])
      txn(vecs[i].which, vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].sel,
          vecs[i].exp_err, vecs[i].exp_dat);

    // Zero-latency master holding STB: write, read-after-write, then reads with ADR moved in RESP.
    b2b_dat = '{LB, LB, LC, LC, LA, LA, LB};
    b2b_ack = '{1, 0, 1, 0, 1, 0, 1};
    @(negedge clk);
    drive(1'b1, 1'b1, 1'b1, 12'h003, LC, 16'hFFFF);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      sample(1'b1, ack, err, ds);
      chk("b2b_ack", 128'(ack), 128'(b2b_ack[i]));
      chk("b2b_dat", ds, b2b_dat[i]);
      if (i == 0) bus0.WE = 1'b0;
      if (i == 2) bus0.ADR = 12'h001;
      if (i == 4) bus0.ADR = 12'h002;
      if (i == 6) drive(1'b1, 1'b0, 1'b0, 12'h000, '0, '0);
    end
    @(negedge clk);
    sample(1'b1, ack, err, ds);
    chk("b2b_tail", 128'(ack), 128'd0);

    // Abort: STB dropped one cycle before the ACK would have appeared.
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 12'h020, ONES, 16'hFFFF);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      sample(1'b0, ack, err, ds);
      chk("abort_wait", 128'(ack | err), 128'd0);
      if (k == 2) drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0);
    end
    repeat (4) begin
      @(negedge clk);
      sample(1'b0, ack, err, ds);
      chk("abort_no_ack", 128'(ack | err), 128'd0);
    end
    txn(1'b0, 1'b0, 12'h020, '0, '0, 1'b0, 128'd0);

    // Reset during WAIT with the request still asserted: nothing committed, nothing accepted.
    txn(1'b0, 1'b1, 12'h030, LP, 16'hFFFF, 1'b0, 128'd0);
    txn(1'b0, 1'b0, 12'h030, '0, '0, 1'b0, LP);
    @(negedge clk);
    drive(1'b0, 1'b1, 1'b1, 12'h030, LQ, 16'hFFFF);
    @(negedge clk);
    sample(1'b0, ack, err, ds);
    chk("rst_mid_wait", 128'(ack), 128'd0);
    rst = 1'b1;
    @(negedge clk);
    sample(1'b0, ack, err, ds);
    chk("rst_mid_ack", 128'(ack), 128'd0);
    chk("rst_mid_dat", ds, 128'd0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 12'h000, '0, '0);
    repeat (5) begin
      @(negedge clk);
      sample(1'b0, ack, err, ds);
      chk("rst_mid_quiet", 128'(ack | err), 128'd0);
    end
    txn(1'b0, 1'b0, 12'h030, '0, '0, 1'b0, LP);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_line_responder.md
Name: wb_line_responder

Overview:
- Wishbone slave that answers the CPU's 128-bit line requests on either the ifetch or the memory port.
- Backed by an internal line array with a programmable response latency. Serves as the behavioural memory endpoint for core bring-up and as the slave half for later cache and arbiter work.
- Accepts one request at a time. Byte-enabled writes and full-line reads are acknowledged with a single-cycle ACK.

Parameters:
- DEPTH, 256, number of 128-bit lines held; line index = ADR modulo 2^clog2(DEPTH), range-checked against DEPTH.
- LATENCY, 3, wait cycles between request acceptance and ACK (0 allowed).
- ADR_W, 12, width of the line address (byte address [15:4]).

Ports:
- clk  in  1  system clock, all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- CYC  in  1  bus cycle valid.
- STB  in  1  strobe; a request is present when CYC & STB.
- WE  in  1  1 = write, 0 = read.
- ADR  in  ADR_W  line address.
- DAT_M  in  128  write data from the master.
- SEL  in  16  byte enables; bit i qualifies DAT_M[8i+7:8i].
- DAT_S  out  128  read data to the master.
- ACK  out  1  single-cycle completion pulse.
- ERR  out  1  error completion; active only with the optional feature.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous, active-high, on rst.
- Reset values: state = IDLE, ACK = 0, ERR = 0, DAT_S = 0, latency counter = 0. Line array contents are not cleared by rst; they are zero at time zero.
- FSM has three states: IDLE, WAIT, RESP.
- IDLE:
  - If CYC & STB, accept the request and capture ADR, WE, DAT_M and SEL into holding registers.
  - Go to RESP if LATENCY = 0; otherwise load counter = LATENCY-1 and go to WAIT.
- WAIT:
  - If CYC & STB is low, abort: go to IDLE, no ACK, no array write.
  - Else if counter = 0, go to RESP; else decrement the counter.
- Entry to RESP (the edge into RESP):
  - Write: for each i with captured SEL[i] = 1, line[idx] byte i <= captured DAT_M byte i; other bytes are unchanged.
  - Read: DAT_S <= line[idx].
  - ACK is 1 for the whole RESP cycle.
- RESP:
  - Lasts exactly one cycle, then go to IDLE unconditionally.
  - ACK falls on the next edge.
  - CYC/STB still high in the cycle after ACK is treated as a new request.
- Latency: request accepted in cycle t means ACK in cycle t+1+LATENCY. Back-to-back requests give one ACK every LATENCY+2 cycles.
- Input stability: ADR, WE, DAT_M and SEL changes after acceptance are ignored; the captured values are used.
- DAT_S holding: DAT_S holds its value until the next read response. Write responses leave DAT_S unchanged.
- Read-after-write: a read accepted in the cycle after a write's ACK returns the written data.
- Out-of-range (idx >= DEPTH, when DEPTH is not a power of two):
  - Read returns 128'h0.
  - Write is dropped.
  - Still ACKed unless the optional feature is enabled.
- SEL = 0 write: acknowledged normally, array unchanged.
- Read SEL: ignored for reads; the full line is returned.
- rst mid-transaction (WAIT or RESP): the next edge forces IDLE, ACK = 0, DAT_S = 0. A pending write whose RESP-entry edge has not occurred is not committed.
- Simultaneous rst and new request: rst wins; the request is not accepted.

Optional Feature:
- Macro: WB_RESP_RANGE_ERR_EN.
- Defined: an out-of-range request completes with ERR = 1 for the RESP cycle and ACK = 0. DAT_S is unchanged and no write occurs. ERR follows the same timing and abort rules as ACK.
- Undefined: ERR is tied 0 and out-of-range requests behave as described in Behaviour.

Test Plan:
1. Reset, LATENCY = 3: write ADR = 12'h010, SEL = 16'hFFFF, DAT_M = 128'h0123...CDEF, accepted at cycle t -> ACK only at t+4, one cycle wide. Read of 12'h010 -> DAT_S = 128'h0123...CDEF during its ACK.
2. Partial write to 12'h010 with SEL = 16'h0003, DAT_M low half-word = 16'hBEEF, then read -> bytes 0-1 = EF, BE; bytes 2-15 unchanged from scenario 1.
3. Drop STB in WAIT one cycle before ACK on a write of 12'h020 (DAT_M = all-ones) -> no ACK. Subsequent read of 12'h020 -> 128'h0.
4. LATENCY = 0, master holds STB high continuously, reading 12'h001 and 12'h002 -> ACK every 2nd cycle. DAT_S changes only on ACK cycles. Changing ADR during RESP does not affect the in-flight response.
5. Assert rst for one cycle while in WAIT for a write to 12'h030 -> ACK stays 0, DAT_S = 0, state IDLE. A later read of 12'h030 returns its pre-write value.
6. DEPTH = 200, read ADR = 12'h0C8 -> ACK with DAT_S = 0 (macro undefined). With WB_RESP_RANGE_ERR_EN defined -> ERR = 1 for one cycle, ACK = 0, DAT_S unchanged.
